// File: rtl/bip_insert_tx.sv
// Per-lane BIP8 fill for 40GBASE-R TX alignment markers, one registered stage.
// BIP_ERR_INJ_EN adds err_inj_i, which arms a one-shot BIP3 bit0 inversion per lane.
module bip_insert_tx #(
  parameter int LANE_N = 4,
  parameter int HEAD_W = 2,
  parameter int DATA_W = 64,
  parameter int BIP_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_i,
  input  logic                       marker_v_i,
  input  logic [LANE_N*HEAD_W-1:0]   head_i,
  input  logic [LANE_N*DATA_W-1:0]   data_i,
`ifdef BIP_ERR_INJ_EN
  input  logic [LANE_N-1:0]          err_inj_i,
`endif
  output logic                       valid_o,
  output logic                       marker_v_o,
  output logic [LANE_N*HEAD_W-1:0]   head_o,
  output logic [LANE_N*DATA_W-1:0]   data_o
);

  if (BIP_W != 8) begin : g_bip_w_err
    $error("bip_insert_tx: BIP_W must be 8");
  end

  // Payload bytes XORed together; header bits land on BIP bits 3 and 4.
  function automatic logic [BIP_W-1:0] bip_calc(input logic [HEAD_W-1:0] h,
                                                input logic [DATA_W-1:0] d);
    logic [BIP_W-1:0] b;
    b = {3'b000, h[1], h[0], 3'b000};
    for (int k = 0; k < DATA_W/8; k++) begin
      b ^= d[k*8 +: 8];
    end
    return b;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_o    <= 1'b0;
      marker_v_o <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        marker_v_o <= marker_v_i;
      end
    end
  end

  for (genvar i = 0; i < LANE_N; i++) begin : g_lane
    logic [HEAD_W-1:0] head_in;
    logic [HEAD_W-1:0] head_q;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_mk;
    logic [DATA_W-1:0] data_nxt;
    logic [DATA_W-1:0] data_q;
    logic [BIP_W-1:0]  acc_q;
    logic [BIP_W-1:0]  bip3;
    logic              inj;

    assign head_in = head_i[i*HEAD_W +: HEAD_W];
    assign data_in = data_i[i*DATA_W +: DATA_W];

`ifdef BIP_ERR_INJ_EN
    logic inj_q;

    // A request arriving on a marker cycle arms the following marker.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        inj_q <= 1'b0;
      end else begin
        inj_q <= (inj_q & ~(valid_i & marker_v_i)) | err_inj_i[i];
      end
    end

    assign inj = inj_q;
`else
    assign inj = 1'b0;
`endif

    always_comb begin
      bip3            = acc_q ^ {{(BIP_W-1){1'b0}}, inj};
      data_mk         = data_in;
      data_mk[31:24]  = bip3;
      data_mk[63:56]  = ~acc_q;
      data_nxt        = marker_v_i ? data_mk : data_in;
    end

    // On a marker the accumulator restarts from the block as transmitted.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        head_q <= '0;
        data_q <= '0;
        acc_q  <= '0;
      end else if (valid_i) begin
        head_q <= head_in;
        data_q <= data_nxt;
        acc_q  <= marker_v_i ? bip_calc(head_in, data_mk)
                             : acc_q ^ bip_calc(head_in, data_in);
      end
    end

    assign head_o[i*HEAD_W +: HEAD_W] = head_q;
    assign data_o[i*DATA_W +: DATA_W] = data_q;
  end

endmodule

// File: tb/tb_bip_insert_tx.sv
// Directed bench for bip_insert_tx with hand-computed BIP values.
// Build with BIP_ERR_INJ_EN to also exercise the error-injection port.
module tb_bip_insert_tx;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid_i = 1'b0;
  logic         marker_v_i = 1'b0;
  logic [7:0]   head_i = '0;
  logic [255:0] data_i = '0;
  logic         valid_o;
  logic         marker_v_o;
  logic [7:0]   head_o;
  logic [255:0] data_o;
`ifdef BIP_ERR_INJ_EN
  logic [3:0]   err_inj_i = '0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Lane marker bytes {M2,M1,M0}; M4..M6 are their complements.
  logic [23:0] mk_pat [4] = '{24'h477690, 24'hE6C4F0, 24'h9B65C5, 24'h3D79A2};

  bip_insert_tx dut (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (valid_i),
    .marker_v_i (marker_v_i),
    .head_i     (head_i),
    .data_i     (data_i),
`ifdef BIP_ERR_INJ_EN
    .err_inj_i  (err_inj_i),
`endif
    .valid_o    (valid_o),
    .marker_v_o (marker_v_o),
    .head_o     (head_o),
    .data_o     (data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_word(input int l, input logic [7:0] b3, input logic [7:0] b7);
    logic [23:0] p;
    p = mk_pat[l];
    return {b7, ~p, b3, p};
  endfunction

  function automatic logic [255:0] mk_bus();
    logic [255:0] d;
    for (int l = 0; l < 4; l++) d[l*64 +: 64] = mk_word(l, 8'hAA, 8'h55);
    return d;
  endfunction

  task automatic cyc(input logic v, input logic m, input logic [7:0] h, input logic [255:0] d);
    valid_i    = v;
    marker_v_i = m;
    head_i     = h;
    data_i     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_marker();
    cyc(1'b1, 1'b1, 8'h55, mk_bus());
  endtask

  task automatic chk_mk(input string tag, input logic [31:0] b3s, input logic [31:0] b7s);
    chk({tag, " valid_o"}, {63'd0, valid_o}, 64'd1);
    chk({tag, " marker_v_o"}, {63'd0, marker_v_o}, 64'd1);
    chk({tag, " head_o"}, {56'd0, head_o}, 64'h55);
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("%s lane%0d", tag, l), data_o[l*64 +: 64],
          mk_word(l, b3s[l*8 +: 8], b7s[l*8 +: 8]));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " valid_o"}, {63'd0, valid_o}, 64'd0);
    chk({tag, " marker_v_o"}, {63'd0, marker_v_o}, 64'd0);
    chk({tag, " head_o"}, {56'd0, head_o}, 64'd0);
    chk({tag, " data_o"}, {63'd0, |data_o}, 64'd0);
  endtask

  initial begin
    int sent;
    int c;
    logic st;

    #12;
    chk_zero("rst");
    @(negedge clk);
    reset = 1'b0;

    cyc(1'b0, 1'b0, 8'h00, '0);
    chk("idle valid_o", {63'd0, valid_o}, 64'd0);

    send_marker();
    chk_mk("mk1", {4{8'h00}}, {4{8'hFF}});

    for (int b = 0; b < 3; b++) begin
      cyc(1'b1, 1'b0, 8'hAA, '0);
      chk("blk marker_v_o", {63'd0, marker_v_o}, 64'd0);
      chk("blk data_o", {63'd0, |data_o}, 64'd0);
    end
    chk("blk head_o", {56'd0, head_o}, 64'hAA);

    send_marker();
    chk_mk("mk2", {4{8'h18}}, {4{8'hE7}});

    // Stall right after a marker: outputs hold, garbage is not absorbed.
    cyc(1'b0, 1'b0, 8'hFF, {8{32'hDEADBEEF}});
    chk("stall valid_o", {63'd0, valid_o}, 64'd0);
    chk("stall marker_v_o", {63'd0, marker_v_o}, 64'd1);
    chk("stall lane2 hold", data_o[128 +: 64], mk_word(2, 8'h18, 8'hE7));

    cyc(1'b1, 1'b0, 8'hAA, '0);
    cyc(1'b1, 1'b0, 8'hAA, '0);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("async rst");
    @(posedge clk);
    #1;
    chk_zero("rst held");
    reset = 1'b0;

    send_marker();
    chk_mk("mk after rst", {4{8'h00}}, {4{8'hFF}});
    send_marker();
    chk_mk("mk b2b", {4{8'h08}}, {4{8'hF7}});

    sent = 0;
    c = 0;
    while (sent < 16383) begin
      st = (c % 33) == 32;
      if (st) begin
        cyc(1'b0, 1'b1, 8'h55, {$urandom, $urandom, $urandom, $urandom,
                                $urandom, $urandom, $urandom, $urandom});
        chk("long stall data_o", {63'd0, |data_o}, 64'd0);
        chk("long stall head_o", {56'd0, head_o}, 64'hAA);
      end else begin
        cyc(1'b1, 1'b0, 8'hAA, '0);
        sent++;
      end
      chk("long valid_o", {63'd0, valid_o}, {63'd0, ~st});
      c++;
    end
    send_marker();
    chk_mk("mk long", {4{8'h18}}, {4{8'hE7}});

`ifdef BIP_ERR_INJ_EN
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    err_inj_i = 4'b0010;
    cyc(1'b0, 1'b0, 8'h00, '0);
    err_inj_i = 4'b0000;
    send_marker();
    chk_mk("inj mk", {8'h00, 8'h00, 8'h01, 8'h00}, {4{8'hFF}});
    send_marker();
    chk_mk("inj next", {8'h08, 8'h08, 8'h09, 8'h08}, {8'hF7, 8'hF7, 8'hF6, 8'hF7});
`endif

    cyc(1'b0, 1'b0, 8'h00, '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bip_insert_tx.md
Name: bip_insert_tx

Overview:
Per-lane BIP8 computation and insertion stage for the 40GBASE-R multi-lane TX PCS. Sits directly downstream of the TX alignment marker inserter, which emits marker blocks with BIP3/BIP7 bytes left undefined. Fills BIP3 with the running per-lane bit-interleaved parity and BIP7 with its complement, then forwards blocks to the per-lane gearbox. Output is registered, with a valid qualifier so the gearbox can insert stall cycles.

Parameters:
LANE_N, 4, number of PCS lanes
HEAD_W, 2, sync header width per lane
DATA_W, 64, payload width per lane
BIP_W, 8, BIP width (fixed at 8; any other value is a configuration error)

Ports:
clk  in  1  clock
reset  in  1  reset
valid_i  in  1  input blocks present on all lanes this cycle; tie high when upstream is free-running
marker_v_i  in  1  current input blocks are alignment markers, all lanes; ignored when valid_i=0
head_i  in  LANE_N*HEAD_W  sync headers, lane i at [i*HEAD_W +: HEAD_W], bit0 transmitted first
data_i  in  LANE_N*DATA_W  payloads, lane i at [i*DATA_W +: DATA_W], bit0 transmitted first
valid_o  out  1  output blocks valid
marker_v_o  out  1  output blocks are markers
head_o  out  LANE_N*HEAD_W  forwarded headers
data_o  out  LANE_N*DATA_W  forwarded payloads, BIP fields filled on markers

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: valid_o=0, marker_v_o=0, head_o=0, data_o=0, all lane accumulators acc[i]=0x00.
- Latency: 1 cycle. Registers update only when valid_i=1. When valid_i=0, valid_o=0 next cycle and data/head/marker_v outputs hold their values.
- Block bit position p (0..65): p=0,1 are head bits 0,1; p=2+k is data bit k.
- BIP bit j accumulates positions p=2+j+8m, for m=0..7. Head bit0 also feeds BIP bit3, and head bit1 feeds BIP bit4. This is equivalent to XOR of the 8 payload bytes, XOR {3'b0, head[1], head[0], 3'b0}.
- Non-marker block (valid_i=1, marker_v_i=0): output is the input unchanged; acc[i] <= acc[i] ^ bip(block_i).
- Marker block (valid_i=1, marker_v_i=1): output payload = input with byte3 (data[31:24]) replaced by acc[i] and byte7 (data[63:56]) replaced by ~acc[i]. Header and other bytes are passed through. Then acc[i] <= bip(outgoing marker block), computed with the inserted BIP bytes, not acc[i] ^ anything.
- BIP covers all blocks from and including the previous marker, excluding the current marker.
- First marker after reset carries BIP3=0x00 and BIP7=0xFF.
- Back-to-back markers: the second marker carries bip(first marker as transmitted). No special casing.
- Reset mid-stream: asynchronous clear of all state. No partial block is emitted; valid_o drops immediately.
- Lanes are independent. No cross-lane state other than the shared valid_i and marker_v_i.

Optional Feature:
Macro BIP_ERR_INJ_EN.
- Defined: adds input port err_inj_i [LANE_N-1:0]. A set bit arms a sticky per-lane flag. On that lane's next marker, the inserted BIP3 bit0 is inverted (BIP7 stays ~ of the uncorrupted value), then the flag clears. The accumulator is reseeded from the corrupted transmitted block. Flags clear on reset.
- Undefined: no port, no flag, no logic.

Test Plan:
- Reset, then marker on all lanes with upstream marker bytes and head=2'b01 -> each lane byte3=0x00, byte7=0xFF; valid_o and marker_v_o high one cycle after input.
- Marker, 3 blocks with data=0 and head=2'b10, marker -> every lane second marker byte3=0x18, byte7=0xE7. First marker contributes 0x08; three data blocks contribute 0x10.
- Same as above with 16383 zero data blocks and valid_i deasserted for 1 of every 33 cycles -> byte3=0x18, byte7=0xE7; valid_o mirrors valid_i delayed by 1 cycle, and data is unchanged through stalls.
- Two consecutive markers after reset -> second marker byte3=0x08, byte7=0xF7 on all lanes.
- Assert reset for 1 cycle mid-gap, then marker -> outputs 0 during reset; marker after reset gives byte3=0x00, byte7=0xFF.
- With BIP_ERR_INJ_EN, pulse err_inj_i=4'b0010, then marker after reset -> lane1 byte3=0x01, byte7=0xFF; other lanes 0x00/0xFF; the following marker on lane1 is not corrupted.
